// File: rtl/max_pool_unit_if.sv
// rtl/max_pool_unit_if.sv - word stream and pooled-result bus between the rotator and the max-pool unit
interface max_pool_unit_if #(
    parameter int WORD_SIZE = 128
);
    logic [4:0]           pool_size;
    logic                 flush;
    logic                 DI_valid;
    logic [WORD_SIZE-1:0] DI;
    logic                 DO_valid;
    logic [WORD_SIZE-1:0] DO;
    logic                 busy;

    modport master (
        output pool_size, flush, DI_valid, DI,
        input  DO_valid, DO, busy
    );

    modport slave (
        input  pool_size, flush, DI_valid, DI,
        output DO_valid, DO, busy
    );
endinterface

// File: rtl/max_pool_unit.sv
// rtl/max_pool_unit.sv - lane-wise int8 max over a window of consecutive rotator words
module max_pool_unit #(
    parameter int WORD_SIZE = 128,
    parameter int LANES     = 8,
    parameter int SIGNED    = 1,
    parameter int MAX_POOL  = 16
) (
    input  logic            clk,
    input  logic            rst,
    max_pool_unit_if.slave  bus
);
    localparam int         LW    = LANES * 8;
    localparam int         PAD   = WORD_SIZE - LW;
    localparam logic [4:0] MAX_N = 5'(MAX_POOL);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t               state, state_nxt;
    logic [4:0]           cnt, cnt_nxt;
    logic [4:0]           win_n, win_n_nxt;
    logic [4:0]           eff_n;
    logic [LW-1:0]        acc, acc_nxt;
    logic [LW-1:0]        di_lanes;
    logic [LW-1:0]        merged;
    logic [LW-1:0]        emit_data;
    logic                 emit;
    logic [WORD_SIZE-1:0] do_q;
    logic                 do_valid_q;
    logic [PAD-1:0]       unused_pad;

    assign di_lanes   = bus.DI[WORD_SIZE-1 -: LW];
    assign unused_pad = bus.DI[PAD-1:0];

    // Window length as it would be latched if this word opened a window.
    always_comb begin
        if (bus.pool_size == 5'd0) begin
            eff_n = 5'd1;
        end else if (bus.pool_size > MAX_N) begin
            eff_n = MAX_N;
        end else begin
            eff_n = bus.pool_size;
        end
    end

    function automatic logic [7:0] lane_max(input logic [7:0] a, input logic [7:0] b);
        logic take_b;
        if (SIGNED != 0) begin
            take_b = $signed(b) > $signed(a);
        end else begin
            take_b = b > a;
        end
        return take_b ? b : a;
    endfunction

    always_comb begin
        merged = '0;
        for (int i = 0; i < LANES; i++) begin
            merged[LW-1-8*i -: 8] = lane_max(acc[LW-1-8*i -: 8], di_lanes[LW-1-8*i -: 8]);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        win_n_nxt = win_n;
        acc_nxt   = acc;
        emit      = 1'b0;
        emit_data = acc;

        case (state)
            IDLE: begin
                // flush alone in IDLE has nothing to emit and is dropped.
                if (bus.DI_valid) begin
                    acc_nxt   = di_lanes;
                    win_n_nxt = eff_n;
                    cnt_nxt   = 5'd1;
                    if (eff_n == 5'd1 || bus.flush) begin
                        emit      = 1'b1;
                        emit_data = di_lanes;
                        cnt_nxt   = 5'd0;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (bus.DI_valid) begin
                    acc_nxt = merged;
                    if (cnt + 5'd1 == win_n || bus.flush) begin
                        emit      = 1'b1;
                        emit_data = merged;
                        cnt_nxt   = 5'd0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end else if (bus.flush) begin
                    emit      = 1'b1;
                    emit_data = acc;
                    cnt_nxt   = 5'd0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            win_n      <= 5'd1;
            acc        <= '0;
            do_q       <= '0;
            do_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            win_n      <= win_n_nxt;
            acc        <= acc_nxt;
            do_valid_q <= emit;
            if (emit) begin
                do_q <= {emit_data, {PAD{1'b0}}};
            end
        end
    end

    assign bus.DO       = do_q;
    assign bus.DO_valid = do_valid_q;
    assign bus.busy     = (state == ACCUM);
endmodule

// File: tb/tb_max_pool_unit.sv
// tb/tb_max_pool_unit.sv - scoreboard bench for signed and unsigned max_pool_unit instances
module tb_max_pool_unit;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   pool_size = 5'd0;
    logic         flush = 1'b0;
    logic         di_valid = 1'b0;
    logic [127:0] di = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses_s = 0;
    int pulses_u = 0;
    int p0;
    bit chk_en   = 1'b0;
    bit busy_cur = 1'b0;
    logic [127:0] last_s = '0;
    logic [127:0] last_u = '0;

    typedef struct {
        int          stamp;
        logic [63:0] val;
    } exp_t;

    exp_t exp_s[$];
    exp_t exp_u[$];
    exp_t e_s, e_u;

    logic [63:0] win[$];
    int          win_n  = 1;
    bit          in_win = 1'b0;

    logic [7:0] l0 [4] = '{8'h80, 8'hff, 8'h05, 8'h7f};
    logic [7:0] b2b [6] = '{8'h01, 8'h09, 8'h04, 8'h03, 8'h10, 8'h0f};
    logic [63:0] w;

    max_pool_unit_if #(.WORD_SIZE(128)) if_s ();
    max_pool_unit_if #(.WORD_SIZE(128)) if_u ();

    assign if_s.pool_size = pool_size;
    assign if_s.flush     = flush;
    assign if_s.DI_valid  = di_valid;
    assign if_s.DI        = di;
    assign if_u.pool_size = pool_size;
    assign if_u.flush     = flush;
    assign if_u.DI_valid  = di_valid;
    assign if_u.DI        = di;

    max_pool_unit #(.WORD_SIZE(128), .LANES(8), .SIGNED(1), .MAX_POOL(16)) dut_s (
        .clk (clk),
        .rst (rst_n),
        .bus (if_s.slave)
    );

    max_pool_unit #(.WORD_SIZE(128), .LANES(8), .SIGNED(0), .MAX_POOL(16)) dut_u (
        .clk (clk),
        .rst (rst_n),
        .bus (if_u.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: max of every word in the window, lane by lane, as integers.
    function automatic logic [63:0] pool_max(input bit sgn);
        logic [63:0] r;
        int best, cand;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            best = sgn ? int'($signed(win[0][63-8*l -: 8])) : int'(win[0][63-8*l -: 8]);
            r[63-8*l -: 8] = win[0][63-8*l -: 8];
            for (int k = 1; k < win.size(); k++) begin
                cand = sgn ? int'($signed(win[k][63-8*l -: 8])) : int'(win[k][63-8*l -: 8]);
                if (cand > best) begin
                    best = cand;
                    r[63-8*l -: 8] = win[k][63-8*l -: 8];
                end
            end
        end
        return r;
    endfunction

    task automatic emit_window();
        exp_s.push_back('{stamp: cyc + 1, val: pool_max(1'b1)});
        exp_u.push_back('{stamp: cyc + 1, val: pool_max(1'b0)});
        in_win = 1'b0;
        win.delete();
    endtask

    task automatic model(input bit v, input logic [63:0] lanes, input bit f, input logic [4:0] ps);
        if (v) begin
            if (!in_win) begin
                win_n  = (ps == 5'd0) ? 1 : ((ps > 5'd16) ? 16 : int'(ps));
                in_win = 1'b1;
                win.delete();
            end
            win.push_back(lanes);
            if (win.size() == win_n || f) emit_window();
        end else if (f && in_win) begin
            emit_window();
        end
    endtask

    task automatic step(input bit v, input logic [63:0] lanes, input bit f, input logic [4:0] ps);
        @(posedge clk);
        #1;
        busy_cur  = in_win;
        di_valid  = v;
        flush     = f;
        pool_size = ps;
        di        = {lanes, 32'($urandom), 32'($urandom)};
        model(v, lanes, f, ps);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, {32'($urandom), 32'($urandom)}, 1'b0, 5'($urandom_range(0, 31)));
    endtask

    task automatic check_reset_outputs();
        check("signed reset DO", if_s.DO, 128'd0);
        check("signed reset DO_valid", 128'(if_s.DO_valid), 128'd0);
        check("signed reset busy", 128'(if_s.busy), 128'd0);
        check("unsigned reset DO", if_u.DO, 128'd0);
        check("unsigned reset DO_valid", 128'(if_u.DO_valid), 128'd0);
        check("unsigned reset busy", 128'(if_u.busy), 128'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (if_s.DO_valid) begin
                pulses_s++;
                last_s = if_s.DO;
                if (exp_s.size() == 0) begin
                    check("signed unexpected pulse", 128'd1, 128'd0);
                end else begin
                    e_s = exp_s.pop_front();
                    check("signed pulse cycle", 128'(cyc), 128'(e_s.stamp));
                    check("signed DO", if_s.DO, {e_s.val, 64'd0});
                end
            end
            if (exp_s.size() != 0 && exp_s[0].stamp < cyc) begin
                check("signed missing pulse", 128'd0, 128'd1);
                void'(exp_s.pop_front());
            end
            if (if_u.DO_valid) begin
                pulses_u++;
                last_u = if_u.DO;
                if (exp_u.size() == 0) begin
                    check("unsigned unexpected pulse", 128'd1, 128'd0);
                end else begin
                    e_u = exp_u.pop_front();
                    check("unsigned pulse cycle", 128'(cyc), 128'(e_u.stamp));
                    check("unsigned DO", if_u.DO, {e_u.val, 64'd0});
                end
            end
            if (exp_u.size() != 0 && exp_u[0].stamp < cyc) begin
                check("unsigned missing pulse", 128'd0, 128'd1);
                void'(exp_u.pop_front());
            end
            check("signed busy", 128'(if_s.busy), 128'(busy_cur));
            check("unsigned busy", 128'(if_u.busy), 128'(busy_cur));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Signed vs unsigned, N = 4
        for (int k = 0; k < 4; k++) step(1'b1, {l0[k], {7{8'(k)}}}, 1'b0, 5'd4);
        idle(3);
        check("signed lane0", 128'(last_s[127:120]), 128'h7f);
        check("signed other lanes", 128'(last_s[119:64]), 128'({7{8'h03}}));
        check("signed pad", 128'(last_s[63:0]), 128'd0);
        check("unsigned lane0", 128'(last_u[127:120]), 128'hff);

        // Back-to-back, N = 2
        p0 = pulses_s;
        for (int k = 0; k < 6; k++) step(1'b1, {8{b2b[k]}}, 1'b0, 5'd2);
        idle(2);
        check("b2b pulse count", 128'(pulses_s - p0), 128'd3);
        check("b2b last lane", 128'(last_s[127:120]), 128'h10);

        // Flush of a partial window, then flush in IDLE, then flush with a word
        step(1'b1, {8{8'h02}}, 1'b0, 5'd8);
        step(1'b1, {8{8'h07}}, 1'b0, 5'd8);
        step(1'b1, {8{8'h05}}, 1'b0, 5'd8);
        step(1'b0, 64'd0, 1'b1, 5'd8);
        idle(2);
        check("flush lane", 128'(last_s[127:120]), 128'h07);
        p0 = pulses_s;
        step(1'b0, 64'd0, 1'b1, 5'd8);
        idle(2);
        check("idle flush no pulse", 128'(pulses_s - p0), 128'd0);
        step(1'b1, {8{8'h02}}, 1'b0, 5'd8);
        step(1'b1, {8{8'h09}}, 1'b1, 5'd8);
        idle(2);
        check("flush with word lane", 128'(last_s[127:120]), 128'h09);

        // pool_size = 0 echoes every word
        p0 = pulses_s;
        for (int k = 0; k < 5; k++) begin
            w = {32'($urandom), 32'($urandom)};
            step(1'b1, w, 1'b0, 5'd0);
        end
        idle(2);
        check("echo pulse count", 128'(pulses_s - p0), 128'd5);
        check("echo last word", last_s[127:64] == w ? 128'd1 : 128'd0, 128'd1);

        // pool_size = 31 clamps to 16
        p0 = pulses_s;
        for (int k = 0; k < 16; k++) step(1'b1, {32'($urandom), 32'($urandom)}, 1'b0, 5'd31);
        idle(2);
        check("clamp pulse count", 128'(pulses_s - p0), 128'd1);

        // Mid-window pool_size changes are ignored
        p0 = pulses_s;
        step(1'b1, {32'($urandom), 32'($urandom)}, 1'b0, 5'd4);
        step(1'b1, {32'($urandom), 32'($urandom)}, 1'b0, 5'd2);
        step(1'b1, {32'($urandom), 32'($urandom)}, 1'b0, 5'd1);
        idle(1);
        check("midchange no early pulse", 128'(pulses_s - p0), 128'd0);
        step(1'b1, {32'($urandom), 32'($urandom)}, 1'b0, 5'd2);
        idle(2);
        check("midchange one pulse", 128'(pulses_s - p0), 128'd1);

        // Reset mid-window discards the partial window
        step(1'b1, {8{8'h7e}}, 1'b0, 5'd4);
        step(1'b1, {8{8'h7e}}, 1'b0, 5'd4);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_win   = 1'b0;
        busy_cur = 1'b0;
        di_valid = 1'b0;
        flush    = 1'b0;
        win.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) step(1'b1, {8{8'(k)}}, 1'b0, 5'd4);
        idle(2);
        check("post-reset lane", 128'(last_s[127:64]), 128'({8{8'h04}}));

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0), {32'($urandom), 32'($urandom)},
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5)));
        end
        step(1'b0, 64'd0, 1'b1, 5'd1);
        idle(4);
        chk_en = 1'b0;
        check("signed queue drained", 128'(exp_s.size()), 128'd0);
        check("unsigned queue drained", 128'(exp_u.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/max_pool_unit.md
Name: max_pool_unit

Overview:
- Downstream consumer of the data rotator stage.
- Each rotator output word carries 8 int8 lanes in DI[127:64]; DI[63:0] is zero padding.
- This block takes the lane-wise maximum over a window of `pool_size` consecutive valid words and emits one pooled word per window, in the same lane layout.
- Feeds the max-pool result path of the accelerator.

Parameters:
- WORD_SIZE, 128, data word width; must match the rotator output.
- LANES, 8, number of 8-bit lanes in the upper half of the word.
- SIGNED, 1, 1 = lanes compared as two's-complement int8; 0 = unsigned.
- MAX_POOL, 16, maximum window length.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- pool_size  input  5  window length; sampled on the first valid word of each window.
- flush  input  1  forces emission of a partial window.
- DI_valid  input  1  DI carries a word this cycle; no backpressure.
- DI  input  WORD_SIZE  lanes in [127:64], lane 0 = DI[127:120]; [63:0] ignored.
- DO_valid  output  1  one-cycle pulse; DO holds a pooled word.
- DO  output  WORD_SIZE  pooled lanes in [127:64], lane 0 = DO[127:120]; [63:0] always 0.
- busy  output  1  high while a window is partially accumulated.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, cnt = 0, acc = 0, DO = 0, DO_valid = 0, busy = 0. A partially accumulated window is discarded with no emission.
- Effective window length N:
  - pool_size = 0 is treated as 1.
  - pool_size > MAX_POOL is clamped to MAX_POOL.
  - N is latched on the first word of each window. pool_size changes mid-window have no effect until the next window.
- States:
  - IDLE: waiting for the first word of a window.
  - ACCUM: window partially filled.
- IDLE + DI_valid: acc = DI[127:64], cnt = 1, latch N.
  - If N == 1 or flush: emit and stay in IDLE.
  - Otherwise go to ACCUM.
- ACCUM + DI_valid: each lane becomes acc_lane = max(acc_lane, DI_lane), compared per SIGNED. cnt increments.
  - If cnt + 1 == N or flush: emit, cnt = 0, go to IDLE.
- ACCUM + flush without DI_valid: emit the current acc, go to IDLE.
- IDLE + flush without DI_valid: ignored. No pulse, no state change.
- Emit:
  - On the clock edge that consumes the window-completing word (or the flush), DO = {max lanes, 64'd0} and DO_valid = 1.
  - Latency: DO_valid is visible in the cycle after the completing DI_valid.
  - DO_valid is high for exactly one cycle.
  - DO holds its value until the next emission.
- Back-to-back windows:
  - The DI_valid in the cycle DO_valid is high starts the next window.
  - No bubbles; full throughput of one word per clock.
- Equal lanes: ties keep the value; the result is identical either way.
- busy = (state == ACCUM).
- Ignored inputs: DI[63:0] is never used. DI and flush are ignored whenever their qualifying condition does not apply.

Test Plan:
- Reset: rst low mid-window, for example after 2 of 4 words.
  - Required: DO = 0, DO_valid = 0, busy = 0 immediately.
  - After release, a fresh 4-word window produces a max computed only from the new words.
- Signed max, N = 4, SIGNED = 1: four words whose lane 0 values are 0x80, 0xFF, 0x05, 0x7F (other lanes 0x00, 0x01, 0x02, 0x03).
  - Required: one DO_valid, 1 cycle after the 4th word.
  - DO[127:120] = 0x7F; other lanes = 0x03; DO[63:0] = 0.
- Unsigned variant, SIGNED = 0, same stimulus.
  - Required: lane 0 = 0xFF.
- Back-to-back windows: N = 2, 6 consecutive valid words carrying lane values 1, 9, 4, 3, 0x10, 0x0F.
  - Required: three DO_valid pulses, spaced 2 cycles apart.
  - Lane results: 0x09, 0x04, 0x10.
- Flush: N = 8, 3 words (lane values 2, 7, 5), then flush alone.
  - Required: DO lane = 0x07; busy drops.
  - A second flush in IDLE produces no pulse.
  - flush together with a DI_valid word of value 9 after 1 word (value 2) emits 0x09.
- pool_size boundaries:
  - pool_size = 0: every word is echoed, lanes unchanged, 1-cycle latency.
  - pool_size = 31: clamps to 16, so exactly one pulse per 16 words.
  - Changing pool_size mid-window does not alter the current window length.
